// File: rtl/seg_pkg.sv
// seg_pkg: shared constants and state type for the 7-segment display arbiter and its sources
package seg_pkg;
  localparam logic [3:0] BLANK = 4'hF;
  localparam int DW = 8;
  typedef enum logic {IDLE = 1'b0, HOLD = 1'b1} state_t;
endpackage

// File: rtl/seg_display_arbiter_if.sv
// seg_display_arbiter_if: sources drive req/dbus (master); arbiter returns gnt/owner/busy/din0/din1 (slave)
interface seg_display_arbiter_if #(parameter int NREQ = 3);
  logic [NREQ-1:0]   req;
  logic [8*NREQ-1:0] dbus;
  logic [NREQ-1:0]   gnt;
  logic [1:0]        owner;
  logic              busy;
  logic [3:0]        din0;
  logic [3:0]        din1;
  modport master (output req, dbus, input gnt, owner, busy, din0, din1);
  modport slave (input req, dbus, output gnt, owner, busy, din0, din1);
endinterface

// File: rtl/seg_rr_pick.sv
// seg_rr_pick: combinational round-robin picker; ports req/ptr/excl_en/excl in, pick/found out
module seg_rr_pick #(parameter int NREQ = 3) (
  input  logic [NREQ-1:0] req,
  input  logic [1:0]      ptr,
  input  logic            excl_en,
  input  logic [1:0]      excl,
  output logic [1:0]      pick,
  output logic            found
);
  int idx;
  always_comb begin
    pick = '0;
    found = 1'b0;
    idx = 0;
    for (int i = 1; i <= NREQ; i++) begin
      idx = (int'(ptr) + i) % NREQ;
      if (!found && req[idx] && !(excl_en && idx == int'(excl))) begin
        found = 1'b1;
        pick = idx[1:0];
      end
    end
  end
endmodule

// File: rtl/seg_display_arbiter.sv
// seg_display_arbiter: round-robin owner of the two-digit display; ports clk, rst (async, active-low), bus (slave)
module seg_display_arbiter
  import seg_pkg::*;
#(
  parameter int NREQ     = 3,
  parameter int HOLD_CYC = 16000000,
  parameter int CNT_W    = 24,
  parameter bit PRIO0    = 1'b1
) (
  input logic clk,
  input logic rst,
  seg_display_arbiter_if.slave bus
);
  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [1:0]       ptr, pick;
  logic             found, sat;
  assign sat = cnt == CNT_W'(HOLD_CYC - 1);
  seg_rr_pick #(.NREQ(NREQ)) u_pick (
    .req(bus.req), .ptr(ptr), .excl_en(state == HOLD), .excl(bus.owner), .pick(pick), .found(found)
  );
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      cnt <= '0;
      ptr <= 2'(NREQ - 1);
      bus.gnt <= '0;
      bus.owner <= '0;
      bus.busy <= 1'b0;
      bus.din0 <= BLANK;
      bus.din1 <= BLANK;
    end else begin
      // data follows the registered owner, so it trails gnt by one cycle
      bus.din0 <= bus.busy ? bus.dbus[DW*bus.owner +: 4] : BLANK;
      bus.din1 <= bus.busy ? bus.dbus[DW*bus.owner+4 +: 4] : BLANK;
      if (state == IDLE) begin
        if (found) begin
          state <= HOLD;
          bus.gnt <= NREQ'(1) << pick;
          bus.owner <= pick;
          bus.busy <= 1'b1;
          ptr <= pick;
          cnt <= '0;
        end
      end else if (!bus.req[bus.owner]) begin
        state <= IDLE;
        bus.gnt <= '0;
        bus.busy <= 1'b0;
      end else if (PRIO0 && bus.req[0] && bus.owner != 2'd0) begin
        bus.gnt <= NREQ'(1);
        bus.owner <= 2'd0;
        ptr <= 2'd0;
        cnt <= '0;
      end else if (sat && found) begin
        bus.gnt <= NREQ'(1) << pick;
        bus.owner <= pick;
        ptr <= pick;
        cnt <= '0;
      end else begin
        cnt <= sat ? cnt : cnt + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_seg_display_arbiter.sv
// tb_seg_display_arbiter: vector table plus scoreboard check of the display arbiter (NREQ=3, HOLD_CYC=4, PRIO0=1)
module tb_seg_display_arbiter;
  typedef struct {
    logic [2:0]  req;
    logic [23:0] dbus;
    logic [2:0]  gnt;
    logic [3:0]  d0;
    logic [3:0]  d1;
  } vec_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int n_cmp = 0;
  int n_err = 0;
  vec_t vecs[$];
  vec_t exp_q[$];
  seg_display_arbiter_if #(.NREQ(3)) bus ();
  seg_display_arbiter #(.NREQ(3), .HOLD_CYC(4), .CNT_W(3), .PRIO0(1'b1)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [23:0] act, input logic [23:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask
  task automatic add(input logic [2:0] r, input logic [23:0] d, input logic [2:0] g, input logic [3:0] a, input logic [3:0] b);
    vec_t v;
    v.req = r; v.dbus = d; v.gnt = g; v.d0 = a; v.d1 = b;
    vecs.push_back(v);
  endtask
  task automatic check_out(input vec_t e, input string tag);
    chk({tag, " gnt"}, 24'(bus.gnt), 24'(e.gnt));
    chk({tag, " busy"}, 24'(bus.busy), 24'(e.gnt != 3'b000));
    if (e.gnt != 3'b000) chk({tag, " owner"}, 24'(bus.owner), e.gnt[2] ? 24'd2 : e.gnt[1] ? 24'd1 : 24'd0);
    chk({tag, " din0"}, 24'(bus.din0), 24'(e.d0));
    chk({tag, " din1"}, 24'(bus.din1), 24'(e.d1));
  endtask
  always @(negedge clk) begin
    if (rst) begin
      n_cmp++;
      if ($countones(bus.gnt) > 1 || bus.busy !== (|bus.gnt)) begin
        n_err++;
        $display("FAIL gnt_onehot: gnt=%b busy=%b", bus.gnt, bus.busy);
      end
    end
  end
  initial begin
    localparam logic [23:0] D = 24'h654321;
    localparam logic [23:0] E = 24'h304321;
    vec_t e;
    add(3'b010, D, 3'b010, 4'hF, 4'hF);
    add(3'b010, D, 3'b010, 4'h3, 4'h4);
    add(3'b000, D, 3'b000, 4'h3, 4'h4);
    add(3'b000, D, 3'b000, 4'hF, 4'hF);
    add(3'b110, D, 3'b100, 4'hF, 4'hF);
    for (int i = 0; i < 3; i++) add(3'b110, D, 3'b100, 4'h5, 4'h6);
    add(3'b110, D, 3'b010, 4'h5, 4'h6);
    for (int i = 0; i < 3; i++) add(3'b110, D, 3'b010, 4'h3, 4'h4);
    add(3'b110, D, 3'b100, 4'h3, 4'h4);
    for (int i = 0; i < 3; i++) add(3'b110, D, 3'b100, 4'h5, 4'h6);
    add(3'b110, D, 3'b010, 4'h5, 4'h6);
    add(3'b110, D, 3'b010, 4'h3, 4'h4);
    add(3'b100, D, 3'b000, 4'h3, 4'h4);
    add(3'b100, D, 3'b100, 4'hF, 4'hF);
    add(3'b100, D, 3'b100, 4'h5, 4'h6);
    add(3'b101, D, 3'b001, 4'h5, 4'h6);
    add(3'b101, D, 3'b001, 4'h1, 4'h2);
    add(3'b100, D, 3'b000, 4'h1, 4'h2);
    add(3'b100, D, 3'b100, 4'hF, 4'hF);
    for (int i = 0; i < 21; i++) add(3'b100, D, 3'b100, 4'h5, 4'h6);
    add(3'b100, E, 3'b100, 4'h0, 4'h3);
    bus.req = 3'b111;
    bus.dbus = D;
    #2 rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    e.gnt = 3'b000; e.d0 = 4'hF; e.d1 = 4'hF;
    check_out(e, "reset");
    @(negedge clk);
    rst = 1'b1;
    bus.req = 3'b000;
    foreach (vecs[i]) begin
      @(negedge clk);
      bus.req = vecs[i].req;
      bus.dbus = vecs[i].dbus;
      exp_q.push_back(vecs[i]);
      @(posedge clk);
      #1;
      if (exp_q.size() == 0) begin
        n_cmp++; n_err++;
        $display("FAIL scoreboard: empty queue at vector %0d", i);
      end else begin
        e = exp_q.pop_front();
        check_out(e, $sformatf("v%0d", i));
      end
    end
    @(posedge clk);
    #2 rst = 1'b0;
    #1;
    e.gnt = 3'b000; e.d0 = 4'hF; e.d1 = 4'hF;
    check_out(e, "async_rst");
    chk("async_rst owner", 24'(bus.owner), 24'd0);
    @(negedge clk);
    rst = 1'b1;
    bus.req = 3'b111;
    @(posedge clk);
    #1;
    e.gnt = 3'b001; e.d0 = 4'hF; e.d1 = 4'hF;
    check_out(e, "relaunch");
    @(posedge clk);
    #1;
    e.d0 = 4'h1; e.d1 = 4'h2;
    check_out(e, "relaunch_data");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
